// File: rtl/data_demux.sv
// Receive-side TDM demultiplexer: aligns to frame_sync, flywheels through missed
// markers and recovers DS1/DS2/DS3 with per-channel valid pulses.
module data_demux #(
  parameter int DATA_W     = 8,
  parameter int MISS_LIMIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mux_data,
  input  logic              mux_valid,
  input  logic              frame_sync,
  input  logic [2:0]        switch_clk_cycles,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] DS1,
  output logic [DATA_W-1:0] DS2,
  output logic [DATA_W-1:0] DS3,
  output logic [2:0]        ds_valid,
  output logic              frame_done,
  output logic              locked,
  output logic              sync_err
);

  localparam int MISS_W = (MISS_LIMIT < 2) ? 1 : $clog2(MISS_LIMIT + 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);

  typedef enum logic {HUNT, TRACK} state_t;

  state_t              r_state;
  logic [1:0]          r_slot;
  logic [2:0]          r_dwell;
  logic [MISS_W-1:0]   r_miss;
  logic [1:0]          r_mode;
  logic [2:0]          r_n;
  logic [DATA_W-1:0]   r_ds1;
  logic [DATA_W-1:0]   r_ds2;
  logic [DATA_W-1:0]   r_ds3;
  logic [2:0]          r_ds_valid;
  logic                r_frame_done;
  logic                r_sync_err;

  state_t              w_next_state;
  logic                w_at_start;
  logic                w_accept;
  logic                w_misalign;
  logic                w_drop;
  logic                w_active;
  logic                w_capture;
  logic                w_last;
  logic [MISS_W-1:0]   w_miss_next;
  logic [1:0]          w_cur_mode;
  logic [2:0]          w_cur_n;
  logic [1:0]          w_cur_c;
  logic [1:0]          w_pos_slot;
  logic [2:0]          w_pos_dwell;
  logic [1:0]          w_next_slot;
  logic [2:0]          w_next_dwell;
  logic [2:0]          w_chan;

  function automatic logic [1:0] chan_count(input logic [1:0] m);
    case (m)
      2'd0:    return 2'd1;
      2'd3:    return 2'd3;
      default: return 2'd2;
    endcase
  endfunction

  // One-hot channel (bit0 = DS1) carried by a given slot under a given mode.
  function automatic logic [2:0] slot_chan(input logic [1:0] m, input logic [1:0] s);
    case (m)
      2'd0:    return 3'b001;
      2'd1:    return (s == 2'd0) ? 3'b001 : 3'b010;
      2'd2:    return (s == 2'd0) ? 3'b010 : 3'b100;
      default: return (s == 2'd0) ? 3'b001 : ((s == 2'd1) ? 3'b010 : 3'b100);
    endcase
  endfunction

  // NOTE: every signal driven here gets a default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_at_start   = (r_slot == 2'd0) && (r_dwell == 3'd0);
    w_accept     = 1'b0;
    w_misalign   = 1'b0;
    w_drop       = 1'b0;
    w_active     = 1'b0;
    w_capture    = 1'b0;
    w_miss_next  = r_miss;
    w_cur_mode   = r_mode;
    w_cur_n      = r_n;
    w_pos_slot   = r_slot;
    w_pos_dwell  = r_dwell;
    w_next_slot  = r_slot;
    w_next_dwell = r_dwell;

    if (mux_valid) begin
      unique case (r_state)
        HUNT: begin
          if (frame_sync) begin
            w_accept     = 1'b1;
            w_next_state = TRACK;
            w_miss_next  = '0;
          end
        end
        TRACK: begin
          if (frame_sync && !w_at_start) begin
            w_misalign  = 1'b1;
            w_accept    = 1'b1;
            w_miss_next = '0;
          end else if (w_at_start) begin
            if (frame_sync) begin
              w_accept    = 1'b1;
              w_miss_next = '0;
            end else if (r_miss >= MISS_LAST) begin
              w_drop       = 1'b1;
              w_next_state = HUNT;
              w_miss_next  = '0;
            end else begin
              // Flywheel: the frame boundary still counts as a frame start.
              w_accept    = 1'b1;
              w_miss_next = r_miss + 1'b1;
            end
          end
        end
        default: w_next_state = HUNT;
      endcase

      if (w_accept) begin
        w_cur_mode  = mode;
        w_cur_n     = (switch_clk_cycles == 3'd0) ? 3'd1 : switch_clk_cycles;
        w_pos_slot  = 2'd0;
        w_pos_dwell = 3'd0;
      end

      w_active = w_accept || ((r_state == TRACK) && !w_drop);

      if (w_active) begin
        w_capture = (w_pos_dwell == 3'd0);
        if (w_pos_dwell == w_cur_n - 3'd1) begin
          w_next_dwell = 3'd0;
          w_next_slot  = (w_pos_slot == w_cur_c - 2'd1) ? 2'd0 : w_pos_slot + 2'd1;
        end else begin
          w_next_dwell = w_pos_dwell + 3'd1;
          w_next_slot  = w_pos_slot;
        end
      end else begin
        w_next_slot  = 2'd0;
        w_next_dwell = 3'd0;
      end
    end
  end

  assign w_cur_c = chan_count(w_cur_mode);
  assign w_chan  = slot_chan(w_cur_mode, w_pos_slot);
  assign w_last  = (w_pos_slot == w_cur_c - 2'd1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= HUNT;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot       <= '0;
      r_dwell      <= '0;
      r_miss       <= '0;
      r_mode       <= '0;
      r_n          <= 3'd1;
      r_ds1        <= '0;
      r_ds2        <= '0;
      r_ds3        <= '0;
      r_ds_valid   <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_ds_valid   <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      if (mux_valid) begin
        r_slot     <= w_next_slot;
        r_dwell    <= w_next_dwell;
        r_miss     <= w_miss_next;
        r_sync_err <= w_misalign;
        if (w_accept) begin
          r_mode <= w_cur_mode;
          r_n    <= w_cur_n;
        end
        if (w_capture) begin
          r_ds_valid   <= w_chan;
          r_frame_done <= w_last;
          if (w_chan[0]) r_ds1 <= mux_data;
          if (w_chan[1]) r_ds2 <= mux_data;
          if (w_chan[2]) r_ds3 <= mux_data;
        end
      end
    end
  end

  assign DS1        = r_ds1;
  assign DS2        = r_ds2;
  assign DS3        = r_ds3;
  assign ds_valid   = r_ds_valid;
  assign frame_done = r_frame_done;
  assign sync_err   = r_sync_err;
  assign locked     = (r_state == TRACK);

endmodule

// File: tb/tb_data_demux.sv
// Directed self-checking bench for data_demux: alignment, flywheel, loss of lock,
// resync, config latching, reset and dwell/mode corner cases.
module tb_data_demux;

  logic       clk;
  logic       rst;
  logic [7:0] mux_data;
  logic       mux_valid;
  logic       frame_sync;
  logic [2:0] switch_clk_cycles;
  logic [1:0] mode;
  logic [7:0] DS1, DS2, DS3;
  logic [2:0] ds_valid;
  logic       frame_done, locked, sync_err;

  int checks = 0;
  int errors = 0;

  data_demux #(.DATA_W(8), .MISS_LIMIT(2)) dut (
    .clk(clk), .rst(rst), .mux_data(mux_data), .mux_valid(mux_valid),
    .frame_sync(frame_sync), .switch_clk_cycles(switch_clk_cycles), .mode(mode),
    .DS1(DS1), .DS2(DS2), .DS3(DS3), .ds_valid(ds_valid),
    .frame_done(frame_done), .locked(locked), .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one input cycle, then sample just after the edge that consumes it.
  task automatic step(input logic [7:0] d, input logic v, input logic s);
    mux_data   = d;
    mux_valid  = v;
    frame_sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                            input logic [7:0] e3, input logic [2:0] edv, input logic efd,
                            input logic elk, input logic ese);
    check({tag, ".DS1"},        32'(DS1),        32'(e1));
    check({tag, ".DS2"},        32'(DS2),        32'(e2));
    check({tag, ".DS3"},        32'(DS3),        32'(e3));
    check({tag, ".ds_valid"},   32'(ds_valid),   32'(edv));
    check({tag, ".frame_done"}, 32'(frame_done), 32'(efd));
    check({tag, ".locked"},     32'(locked),     32'(elk));
    check({tag, ".sync_err"},   32'(sync_err),   32'(ese));
  endtask

  initial begin
    rst = 1'b1; mux_data = '0; mux_valid = 1'b0; frame_sync = 1'b0;
    mode = 2'd3; switch_clk_cycles = 3'd2;

    step(8'd0, 1'b0, 1'b0);
    step(8'd0, 1'b1, 1'b1);
    expect_all("reset", 0, 0, 0, 3'b000, 0, 0, 0);
    rst = 1'b0;

    // Mode 3, dwell 2: acquire and capture one full frame.
    step(8'd3,  1, 1); expect_all("f1.ds1",   3,  0,  0, 3'b001, 0, 1, 0);
    step(8'd3,  1, 0); expect_all("f1.dw1",   3,  0,  0, 3'b000, 0, 1, 0);
    step(8'd50, 1, 0); expect_all("f1.ds2",   3, 50,  0, 3'b010, 0, 1, 0);
    step(8'd50, 1, 0); expect_all("f1.dw3",   3, 50,  0, 3'b000, 0, 1, 0);
    step(8'd98, 1, 0); expect_all("f1.ds3",   3, 50, 98, 3'b100, 1, 1, 0);
    step(8'd98, 1, 0); expect_all("f1.dw5",   3, 50, 98, 3'b000, 0, 1, 0);

    // Valid gap inside the DS2 slot; sync without valid must be ignored.
    step(8'd6,   1, 1); expect_all("f2.ds1",  6, 50, 98, 3'b001, 0, 1, 0);
    step(8'd6,   1, 0); expect_all("f2.dw1",  6, 50, 98, 3'b000, 0, 1, 0);
    step(8'd53,  1, 0); expect_all("f2.ds2",  6, 53, 98, 3'b010, 0, 1, 0);
    step(8'd77,  0, 1); expect_all("f2.gap0", 6, 53, 98, 3'b000, 0, 1, 0);
    step(8'd77,  0, 0); expect_all("f2.gap1", 6, 53, 98, 3'b000, 0, 1, 0);
    step(8'd53,  1, 0); expect_all("f2.dw3",  6, 53, 98, 3'b000, 0, 1, 0);
    step(8'd100, 1, 0); expect_all("f2.ds3",  6, 53, 100, 3'b100, 1, 1, 0);
    step(8'd100, 1, 0); expect_all("f2.dw5",  6, 53, 100, 3'b000, 0, 1, 0);

    // Misaligned sync on dwell 1 of the DS2 slot realigns the frame.
    step(8'd7,  1, 1); expect_all("f3.ds1",   7,  53, 100, 3'b001, 0, 1, 0);
    step(8'd7,  1, 0); expect_all("f3.dw1",   7,  53, 100, 3'b000, 0, 1, 0);
    step(8'd8,  1, 0); expect_all("f3.ds2",   7,   8, 100, 3'b010, 0, 1, 0);
    step(8'd9,  1, 1); expect_all("f3.resync",9,   8, 100, 3'b001, 0, 1, 1);
    step(8'd9,  1, 0); expect_all("f3.rdw1",  9,   8, 100, 3'b000, 0, 1, 0);
    step(8'd10, 1, 0); expect_all("f3.rds2",  9,  10, 100, 3'b010, 0, 1, 0);
    step(8'd10, 1, 0); expect_all("f3.rdw3",  9,  10, 100, 3'b000, 0, 1, 0);
    step(8'd11, 1, 0); expect_all("f3.rds3",  9,  10,  11, 3'b100, 1, 1, 0);
    step(8'd11, 1, 0); expect_all("f3.rdw5",  9,  10,  11, 3'b000, 0, 1, 0);

    // Two missing markers: flywheel once, then drop lock without capturing.
    step(8'd12, 1, 0); expect_all("miss1.ds1", 12, 10, 11, 3'b001, 0, 1, 0);
    step(8'd12, 1, 0); expect_all("miss1.dw1", 12, 10, 11, 3'b000, 0, 1, 0);
    step(8'd13, 1, 0); expect_all("miss1.ds2", 12, 13, 11, 3'b010, 0, 1, 0);
    step(8'd13, 1, 0); expect_all("miss1.dw3", 12, 13, 11, 3'b000, 0, 1, 0);
    step(8'd14, 1, 0); expect_all("miss1.ds3", 12, 13, 14, 3'b100, 1, 1, 0);
    step(8'd14, 1, 0); expect_all("miss1.dw5", 12, 13, 14, 3'b000, 0, 1, 0);
    step(8'd15, 1, 0); expect_all("miss2.drop",12, 13, 14, 3'b000, 0, 0, 0);
    step(8'd16, 1, 0); expect_all("hunt.idle", 12, 13, 14, 3'b000, 0, 0, 0);
    step(8'd20, 1, 1); expect_all("relock",    20, 13, 14, 3'b001, 0, 1, 0);

    // Mode change mid-frame takes effect only at the next frame start.
    mode = 2'd1;
    step(8'd20, 1, 0); expect_all("mc.dw1",  20, 13, 14, 3'b000, 0, 1, 0);
    step(8'd21, 1, 0); expect_all("mc.ds2",  20, 21, 14, 3'b010, 0, 1, 0);
    step(8'd21, 1, 0); expect_all("mc.dw3",  20, 21, 14, 3'b000, 0, 1, 0);
    step(8'd22, 1, 0); expect_all("mc.ds3",  20, 21, 22, 3'b100, 1, 1, 0);
    step(8'd22, 1, 0); expect_all("mc.dw5",  20, 21, 22, 3'b000, 0, 1, 0);
    step(8'd30, 1, 1); expect_all("m1.ds1",  30, 21, 22, 3'b001, 0, 1, 0);
    step(8'd30, 1, 0); expect_all("m1.dw1",  30, 21, 22, 3'b000, 0, 1, 0);
    step(8'd31, 1, 0); expect_all("m1.ds2",  30, 31, 22, 3'b010, 1, 1, 0);
    step(8'd31, 1, 0); expect_all("m1.dw3",  30, 31, 22, 3'b000, 0, 1, 0);
    step(8'd32, 1, 1); expect_all("m1.next", 32, 31, 22, 3'b001, 0, 1, 0);

    // Reset mid-frame discards everything; HUNT ignores unsynced data.
    rst = 1'b1;
    step(8'd33, 1, 0); expect_all("rst.mid",  0, 0, 0, 3'b000, 0, 0, 0);
    rst = 1'b0;
    step(8'd34, 1, 0); expect_all("rst.hunt", 0, 0, 0, 3'b000, 0, 0, 0);

    // Mode 2 with dwell 0 (treated as 1): DS1 never touched.
    mode = 2'd2; switch_clk_cycles = 3'd0;
    step(8'd55,  1, 1); expect_all("m2.a.ds2", 0, 55,   0, 3'b010, 0, 1, 0);
    step(8'd120, 1, 0); expect_all("m2.a.ds3", 0, 55, 120, 3'b100, 1, 1, 0);
    step(8'd56,  1, 1); expect_all("m2.b.ds2", 0, 56, 120, 3'b010, 0, 1, 0);
    step(8'd121, 1, 0); expect_all("m2.b.ds3", 0, 56, 121, 3'b100, 1, 1, 0);

    // Mode 0, dwell 1: every valid cycle is a frame start and a DS1 capture.
    mode = 2'd0; switch_clk_cycles = 3'd1;
    step(8'd40, 1, 1); expect_all("m0.a", 40, 56, 121, 3'b001, 1, 1, 0);
    step(8'd41, 1, 1); expect_all("m0.b", 41, 56, 121, 3'b001, 1, 1, 0);
    step(8'd42, 1, 0); expect_all("m0.fly", 42, 56, 121, 3'b001, 1, 1, 0);
    step(8'd43, 1, 0); expect_all("m0.drop", 42, 56, 121, 3'b000, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
